// File: rtl/smoke_call_initiator.sv
`default_nettype none
// ============================================================================
// Module  : smoke_call_initiator
// Brief   : HDL-side caller of the smoke "inc" RPC; one tagged call in flight.
//           Optional macro SMOKE_CALL_INITIATOR_TIMEOUT_EN adds a WAIT timeout.
// Revision: 1.0 - initial release
// ============================================================================
module smoke_call_initiator #(
    parameter int unsigned DATA_W    = 32,
    parameter int unsigned ID_W      = 8,
    parameter int unsigned METHOD_ID = 0,
    parameter int unsigned TAG_W     = 4,
    parameter int unsigned TIMEOUT   = 1024,
    parameter int unsigned CNT_W     = 16
) (
    input  logic              clock,
    input  logic              reset_n,
    input  logic              req_valid,
    output logic              req_ready,
    input  logic [DATA_W-1:0] req_data,
    output logic              call_valid,
    input  logic              call_ready,
    output logic [ID_W-1:0]   call_id,
    output logic [TAG_W-1:0]  call_tag,
    output logic [DATA_W-1:0] call_arg,
    input  logic              ret_valid,
    input  logic [TAG_W-1:0]  ret_tag,
    input  logic [DATA_W-1:0] ret_val,
    output logic              rsp_valid,
    input  logic              rsp_ready,
    output logic [DATA_W-1:0] rsp_data,
    output logic              rsp_err,
    output logic              busy,
    output logic [CNT_W-1:0]  calls_done
);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_CALL = 2'd1,
        S_WAIT = 2'd2,
        S_RESP = 2'd3
    } state_t;

    state_t              state_q, state_d;
    logic [TAG_W-1:0]    tag_q, tag_d;
    logic [CNT_W-1:0]    calls_done_q, calls_done_d;
    logic [DATA_W-1:0]   call_arg_q, call_arg_d;
    logic [DATA_W-1:0]   rsp_data_q, rsp_data_d;
    logic                ret_match;

    // A timeout window shorter than two cycles cannot be counted.
    if (TIMEOUT < 2) begin : g_bad_timeout
        $error("smoke_call_initiator: TIMEOUT must be at least 2");
    end

    assign ret_match = ret_valid && (ret_tag == tag_q);

`ifdef SMOKE_CALL_INITIATOR_TIMEOUT_EN
    localparam int unsigned      TMO_W    = $clog2(TIMEOUT);
    localparam logic [TMO_W-1:0] TMO_LAST = TMO_W'(TIMEOUT - 1);

    logic [TMO_W-1:0] tmo_q, tmo_d;
    logic             rsp_err_q, rsp_err_d;
`endif

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            state_q      <= S_IDLE;
            tag_q        <= '0;
            calls_done_q <= '0;
            call_arg_q   <= '0;
            rsp_data_q   <= '0;
`ifdef SMOKE_CALL_INITIATOR_TIMEOUT_EN
            tmo_q        <= '0;
            rsp_err_q    <= 1'b0;
`endif
        end else begin
            state_q      <= state_d;
            tag_q        <= tag_d;
            calls_done_q <= calls_done_d;
            call_arg_q   <= call_arg_d;
            rsp_data_q   <= rsp_data_d;
`ifdef SMOKE_CALL_INITIATOR_TIMEOUT_EN
            tmo_q        <= tmo_d;
            rsp_err_q    <= rsp_err_d;
`endif
        end
    end

    always_comb begin
        state_d      = state_q;
        tag_d        = tag_q;
        calls_done_d = calls_done_q;
        call_arg_d   = call_arg_q;
        rsp_data_d   = rsp_data_q;
`ifdef SMOKE_CALL_INITIATOR_TIMEOUT_EN
        tmo_d        = tmo_q;
        rsp_err_d    = rsp_err_q;
`endif
        case (state_q)
            S_IDLE: begin
                if (req_valid) begin
                    call_arg_d = req_data;
                    state_d    = S_CALL;
                end
            end
            S_CALL: begin
                if (call_ready) begin
                    state_d = S_WAIT;
`ifdef SMOKE_CALL_INITIATOR_TIMEOUT_EN
                    tmo_d   = '0;
`endif
                end
            end
            S_WAIT: begin
                // A matching return beats a timeout expiring in the same cycle.
                if (ret_match) begin
                    rsp_data_d = ret_val;
                    state_d    = S_RESP;
`ifdef SMOKE_CALL_INITIATOR_TIMEOUT_EN
                    rsp_err_d  = 1'b0;
                end else if (tmo_q == TMO_LAST) begin
                    rsp_data_d = '0;
                    rsp_err_d  = 1'b1;
                    state_d    = S_RESP;
                end else begin
                    tmo_d      = tmo_q + 1'b1;
`endif
                end
            end
            S_RESP: begin
                if (rsp_ready) begin
                    tag_d   = tag_q + 1'b1;
                    state_d = S_IDLE;
                    if (calls_done_q != '1) begin
                        calls_done_d = calls_done_q + 1'b1;
                    end
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    assign req_ready  = (state_q == S_IDLE);
    assign call_valid = (state_q == S_CALL);
    assign rsp_valid  = (state_q == S_RESP);
    assign busy       = (state_q != S_IDLE);
    assign call_id    = ID_W'(METHOD_ID);
    assign call_tag   = tag_q;
    assign call_arg   = call_arg_q;
    assign rsp_data   = rsp_data_q;
    assign calls_done = calls_done_q;
`ifdef SMOKE_CALL_INITIATOR_TIMEOUT_EN
    assign rsp_err    = rsp_err_q;
`else
    assign rsp_err    = 1'b0;
`endif

endmodule
`default_nettype wire
